// File: rtl/ac_sweep_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// Module   : ac_sweep_pkg
// Purpose  : sweep state encoding, default widths, saturating |x|
// Revision : 1.0  initial release
// ------------------------------------------------------------------
package ac_sweep_pkg;
  localparam int c_fw_default   = 24;
  localparam int c_sw_default   = 16;
  localparam int c_dw_default   = 16;
  localparam int c_navg_default = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PROGRAM = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_EMIT    = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  // The most-negative code has no positive twin; clamp it to full scale.
  function automatic logic [c_dw_default-1:0] abs_sat(input logic signed [c_dw_default-1:0] i_x);
    logic [c_dw_default-1:0] w_r;
    if (i_x == {1'b1, {(c_dw_default-1){1'b0}}})
      w_r = {1'b0, {(c_dw_default-1){1'b1}}};
    else if (i_x[c_dw_default-1])
      w_r = -i_x;
    else
      w_r = i_x;
    return w_r;
  endfunction
endpackage
`default_nettype wire

// File: rtl/ac_mag_accum.sv
`default_nettype none
// ------------------------------------------------------------------
// Module   : ac_mag_accum
// Purpose  : accumulates |sample| over 2^NAVG_LOG2 strobes, returns mean
// Revision : 1.0  initial release
// ------------------------------------------------------------------
module ac_mag_accum
  import ac_sweep_pkg::*;
#(
  parameter int DW        = c_dw_default,
  parameter int NAVG_LOG2 = c_navg_default
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_sample,
  output logic        [DW-1:0] o_mag,
  output logic                 o_last
);
  localparam int AW = DW + NAVG_LOG2;

  logic [AW-1:0]        r_acc;
  logic [NAVG_LOG2-1:0] r_cnt;
  logic [DW-1:0]        w_abs;
  logic [AW-1:0]        w_sum;

  assign w_abs  = abs_sat(i_sample);
  assign w_sum  = r_acc + {{NAVG_LOG2{1'b0}}, w_abs};
  // Mean includes the sample being accepted on the final strobe.
  assign o_mag  = w_sum[AW-1:NAVG_LOG2];
  assign o_last = i_en && (r_cnt == {NAVG_LOG2{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/ac_sweep_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// Module   : ac_sweep_sequencer
// Purpose  : stepped AC sweep: program DDS, settle, average |Vout|, emit
// Revision : 1.0  initial release
// ------------------------------------------------------------------
module ac_sweep_sequencer
  import ac_sweep_pkg::*;
#(
  parameter int FW        = c_fw_default,
  parameter int SW        = c_sw_default,
  parameter int DW        = c_dw_default,
  parameter int NAVG_LOG2 = c_navg_default
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [FW-1:0]        i_f_start,
  input  logic [FW-1:0]        i_f_step,
  input  logic [15:0]          i_n_points,
  input  logic [SW-1:0]        i_settle_cycles,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [FW-1:0]        o_src_freq,
  output logic                 o_src_valid,
  input  logic                 i_src_ready,
  input  logic signed [DW-1:0] i_adc_sample,
  input  logic                 i_adc_valid,
  output logic [FW-1:0]        o_res_freq,
  output logic [DW-1:0]        o_res_mag,
  output logic                 o_res_valid,
  input  logic                 i_res_ready
);
  state_t        r_state, w_next;
  logic [FW-1:0] r_cur_freq, r_f_step, r_res_freq;
  logic [SW-1:0] r_settle, r_settle_cnt;
  logic [15:0]   r_pts_left;
  logic [DW-1:0] r_res_mag, w_mag;
  logic          r_done, w_last, w_clr, w_en, w_go, w_src_hs, w_res_hs;

  // Abort overrides every handshake in the same cycle.
  assign w_go     = i_start && !i_abort;
  assign w_src_hs = (r_state == S_PROGRAM) && i_src_ready && !i_abort;
  assign w_res_hs = (r_state == S_EMIT) && i_res_ready && !i_abort;
  assign w_en     = (r_state == S_MEASURE) && i_adc_valid && !i_abort;
  assign w_clr    = (r_state == S_IDLE) || i_abort || w_res_hs;

  ac_mag_accum #(
    .DW        (DW),
    .NAVG_LOG2 (NAVG_LOG2)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .i_sample (i_adc_sample),
    .o_mag    (w_mag),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_go) w_next = (i_n_points == 16'd0) ? S_FINISH : S_PROGRAM;
      S_PROGRAM: if (i_src_ready) w_next = (r_settle == '0) ? S_MEASURE : S_SETTLE;
      S_SETTLE:  if (r_settle_cnt == SW'(1)) w_next = S_MEASURE;
      S_MEASURE: if (w_last) w_next = S_EMIT;
      S_EMIT:    if (i_res_ready) w_next = (r_pts_left == 16'd1) ? S_FINISH : S_PROGRAM;
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (i_abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_freq   <= '0;
      r_f_step     <= '0;
      r_res_freq   <= '0;
      r_res_mag    <= '0;
      r_settle     <= '0;
      r_settle_cnt <= '0;
      r_pts_left   <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (r_state == S_FINISH) && !i_abort;
      if ((r_state == S_IDLE) && w_go) begin
        r_f_step   <= i_f_step;
        r_pts_left <= i_n_points;
        r_settle   <= i_settle_cycles;
        r_cur_freq <= i_f_start;
      end
      if (w_src_hs)
        r_settle_cnt <= r_settle;
      else if (r_state == S_SETTLE)
        r_settle_cnt <= r_settle_cnt - SW'(1);
      if (w_last) begin
        r_res_mag  <= w_mag;
        r_res_freq <= r_cur_freq;
      end
      if (w_res_hs) begin
        r_pts_left <= r_pts_left - 16'd1;
        r_cur_freq <= r_cur_freq + r_f_step;
      end
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_src_valid = (r_state == S_PROGRAM);
  assign o_src_freq  = r_cur_freq;
  assign o_res_valid = (r_state == S_EMIT);
  assign o_res_freq  = r_res_freq;
  assign o_res_mag   = r_res_mag;
endmodule
`default_nettype wire
